// File: rtl/bonsai_merge_ctrl.sv
// Two-way merge of zero-key-terminated sorted runs from two FWFT FIFOs into one output FIFO.
// Optional completed-run counter is built when BONSAI_MERGE_RUN_CNT_EN is defined.
module bonsai_merge_ctrl #(
  parameter int DATA_W     = 64,
  parameter int KEY_W      = 32,
  parameter int DESCENDING = 0,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_empty,
  output logic              o_a_pop,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_empty,
  output logic              o_b_pop,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_push,
  input  logic              i_out_full,
  output logic              o_stall,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_run_count
);

  typedef enum logic [1:0] {
    NOMINAL = 2'b00,
    DONE_A  = 2'b01,
    DONE_B  = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  state_t            state_reg, state_next;
  logic [KEY_W-1:0]  key_a, key_b;
  logic              a_term, b_term, a_wins;
  logic              fire, a_pop, b_pop;
  logic [DATA_W-1:0] emit_data;
  logic              out_push_reg;
  logic [DATA_W-1:0] out_data_reg;

  assign key_a  = i_a_data[DATA_W-1 -: KEY_W];
  assign key_b  = i_b_data[DATA_W-1 -: KEY_W];
  assign a_term = (key_a == '0);
  assign b_term = (key_b == '0);
  // Ties always go to A so equal keys keep their stream order.
  assign a_wins = (DESCENDING != 0) ? (key_a >= key_b) : (key_a <= key_b);

  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    a_pop      = 1'b0;
    b_pop      = 1'b0;
    emit_data  = '0;
    case (state_reg)
      NOMINAL: begin
        if (i_rst_n && !i_out_full && !i_a_empty && !i_b_empty) begin
          fire = 1'b1;
          if (a_term && b_term) begin
            a_pop = 1'b1;
            b_pop = 1'b1;
          end else if (a_term) begin
            emit_data  = i_b_data;
            b_pop      = 1'b1;
            state_next = DONE_A;
          end else if (b_term) begin
            emit_data  = i_a_data;
            a_pop      = 1'b1;
            state_next = DONE_B;
          end else if (a_wins) begin
            emit_data = i_a_data;
            a_pop     = 1'b1;
          end else begin
            emit_data = i_b_data;
            b_pop     = 1'b1;
          end
        end
      end
      DONE_A: begin
        if (i_rst_n && !i_out_full && !i_b_empty) begin
          fire = 1'b1;
          if (b_term) begin
            a_pop      = 1'b1;
            b_pop      = 1'b1;
            state_next = NOMINAL;
          end else begin
            emit_data = i_b_data;
            b_pop     = 1'b1;
          end
        end
      end
      DONE_B: begin
        if (i_rst_n && !i_out_full && !i_a_empty) begin
          fire = 1'b1;
          if (a_term) begin
            a_pop      = 1'b1;
            b_pop      = 1'b1;
            state_next = NOMINAL;
          end else begin
            emit_data = i_a_data;
            a_pop     = 1'b1;
          end
        end
      end
      default: state_next = NOMINAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= NOMINAL;
      out_push_reg <= 1'b0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      out_push_reg <= fire;
      if (fire) out_data_reg <= emit_data;
    end
  end

`ifdef BONSAI_MERGE_RUN_CNT_EN
  logic             run_end;
  logic [CNT_W-1:0] run_count_reg;

  // Popping both heads happens only when the shared terminator is emitted.
  assign run_end = a_pop & b_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) run_count_reg <= '0;
    else if (run_end) run_count_reg <= run_count_reg + CNT_W'(1);
  end

  assign o_run_count = run_count_reg;
`else
  assign o_run_count = '0;
`endif

  assign o_a_pop    = a_pop;
  assign o_b_pop    = b_pop;
  assign o_stall    = ~fire;
  assign o_state    = state_reg;
  assign o_out_push = out_push_reg;
  assign o_out_data = out_data_reg;

endmodule

// File: tb/tb_bonsai_merge_ctrl.sv
// Bench for bonsai_merge_ctrl: an ascending and a descending instance driven from shared FIFO queues,
// checked against a stable-sort reference of each run pair.
module tb_bonsai_merge_ctrl;
  localparam int DATA_W = 64;
  localparam int KEY_W  = 32;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [1:0]        src;  // 1: from A, 2: from B, 3: terminator (both)
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              sel = 1'b0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_empty = 1'b1, b_empty = 1'b1, out_full = 1'b0;

  logic [DATA_W-1:0] out_data0, out_data1;
  logic              out_push0, out_push1, a_pop0, a_pop1, b_pop0, b_pop1, stall0, stall1;
  logic [1:0]        state0, state1;
  logic [CNT_W-1:0]  rc0, rc1;

  bonsai_merge_ctrl #(.DATA_W(DATA_W), .KEY_W(KEY_W), .DESCENDING(0), .CNT_W(CNT_W)) dut_asc (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_data(a_data), .i_a_empty(sel ? 1'b1 : a_empty), .o_a_pop(a_pop0),
    .i_b_data(b_data), .i_b_empty(sel ? 1'b1 : b_empty), .o_b_pop(b_pop0),
    .o_out_data(out_data0), .o_out_push(out_push0), .i_out_full(sel ? 1'b0 : out_full),
    .o_stall(stall0), .o_state(state0), .o_run_count(rc0)
  );

  bonsai_merge_ctrl #(.DATA_W(DATA_W), .KEY_W(KEY_W), .DESCENDING(1), .CNT_W(CNT_W)) dut_desc (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_data(a_data), .i_a_empty(sel ? a_empty : 1'b1), .o_a_pop(a_pop1),
    .i_b_data(b_data), .i_b_empty(sel ? b_empty : 1'b1), .o_b_pop(b_pop1),
    .o_out_data(out_data1), .o_out_push(out_push1), .i_out_full(sel ? out_full : 1'b0),
    .o_stall(stall1), .o_state(state1), .o_run_count(rc1)
  );

  logic [DATA_W-1:0] out_data;
  logic              out_push, a_pop, b_pop, stall;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  run_count;
  assign out_data  = sel ? out_data1 : out_data0;
  assign out_push  = sel ? out_push1 : out_push0;
  assign a_pop     = sel ? a_pop1 : a_pop0;
  assign b_pop     = sel ? b_pop1 : b_pop0;
  assign stall     = sel ? stall1 : stall0;
  assign state_o   = sel ? state1 : state0;
  assign run_count = sel ? rc1 : rc0;

  logic [DATA_W-1:0] qa[$], qb[$], ra[$], rb[$];
  exp_t              exp_q[$];
  bit                known_a, known_b, a_shown, b_shown, exp_push;
  logic [DATA_W-1:0] exp_data;
  logic [CNT_W-1:0]  rc_exp[2];
  int                n_tests = 0, n_fail = 0;

  function automatic logic [KEY_W-1:0] key(input logic [DATA_W-1:0] d);
    return d[DATA_W-1 -: KEY_W];
  endfunction

  function automatic int rem_a();
    foreach (qa[i]) if (key(qa[i]) == '0) return i;
    return qa.size();
  endfunction

  function automatic int rem_b();
    foreach (qb[i]) if (key(qb[i]) == '0) return i;
    return qb.size();
  endfunction

  function automatic logic [1:0] exp_state();
    if (known_a) return 2'b01;
    if (known_b) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] rc_expected();
`ifdef BONSAI_MERGE_RUN_CNT_EN
    return rc_exp[sel];
`else
    return '0;
`endif
  endfunction

  task automatic push_a(input int k);
    ra.push_back({k[31:0], $urandom});
  endtask

  task automatic push_b(input int k);
    rb.push_back({k[31:0], $urandom});
  endtask

  // Expected output of a run pair: stable sort of A-then-B by key, then a zero terminator.
  task automatic close_run();
    exp_t l[$];
    exp_t s[$];
    exp_t x;
    int   p;
    foreach (ra[i]) begin x.d = ra[i]; x.src = 2'd1; l.push_back(x); qa.push_back(ra[i]); end
    foreach (rb[i]) begin x.d = rb[i]; x.src = 2'd2; l.push_back(x); qb.push_back(rb[i]); end
    foreach (l[i]) begin
      p = 0;
      foreach (s[j]) if (sel ? (key(s[j].d) >= key(l[i].d)) : (key(s[j].d) <= key(l[i].d))) p++;
      s.insert(p, l[i]);
    end
    foreach (s[i]) exp_q.push_back(s[i]);
    x.d = '0; x.src = 2'd3;
    exp_q.push_back(x);
    qa.push_back({32'h0, $urandom});
    qb.push_back({32'h0, $urandom});
    ra.delete();
    rb.delete();
  endtask

  task automatic add_random_run(input int maxlen);
    int ka[$];
    int kb[$];
    int n;
    n = $urandom_range(0, maxlen);
    for (int i = 0; i < n; i++) ka.push_back($urandom_range(1, 40));
    n = $urandom_range(0, maxlen);
    for (int i = 0; i < n; i++) kb.push_back($urandom_range(1, 40));
    if (sel) begin ka.rsort(); kb.rsort(); end
    else begin ka.sort(); kb.sort(); end
    foreach (ka[i]) push_a(ka[i]);
    foreach (kb[i]) push_b(kb[i]);
    close_run();
  endtask

  task automatic flush_model();
    qa.delete(); qb.delete(); exp_q.delete();
    known_a = 0; known_b = 0; a_shown = 0; b_shown = 0; exp_push = 0;
  endtask

  // Called at a falling edge; every cycle checks registered outputs, then combinational pops/stall.
  task automatic run_merge(input int full_pct, input int empty_pct, input int hold_start,
                           input int hold_len, input int max_cyc, input bit partial);
    int   c;
    bit   full, fire, pa, pb;
    int   rema, remb;
    exp_t e;
    c = 0;
    e = '0;
    forever begin
      n_tests++;
      if (out_push !== exp_push || (exp_push && out_data !== exp_data)) begin
        n_fail++;
        $display("FAIL out_record: got push=%0b data=%h, expected push=%0b data=%h",
                 out_push, out_data, exp_push, exp_data);
      end
      n_tests++;
      if (state_o !== exp_state()) begin
        n_fail++;
        $display("FAIL state: got %0d expected %0d", state_o, exp_state());
      end
      n_tests++;
      if (run_count !== rc_expected()) begin
        n_fail++;
        $display("FAIL run_count: got %0d expected %0d", run_count, rc_expected());
      end
      if (!partial && exp_q.size() == 0) break;
      if (c == max_cyc) begin
        if (!partial) begin
          n_tests++; n_fail++;
          $display("FAIL timeout: %0d records still pending after %0d cycles", exp_q.size(), c);
        end
        break;
      end
      full = ((c >= hold_start) && (c < hold_start + hold_len)) || ($urandom_range(0, 99) < full_pct);
      a_shown = a_shown || (qa.size() > 0 && $urandom_range(0, 99) >= empty_pct);
      b_shown = b_shown || (qb.size() > 0 && $urandom_range(0, 99) >= empty_pct);
      a_empty  = !a_shown;
      b_empty  = !b_shown;
      a_data   = a_shown ? qa[0] : {$urandom, $urandom};
      b_data   = b_shown ? qb[0] : {$urandom, $urandom};
      out_full = full;
      #1;
      rema = rem_a();
      remb = rem_b();
      fire = !full && (known_a || a_shown) && (known_b || b_shown) && exp_q.size() > 0;
      pa = 0; pb = 0;
      if (fire) begin
        e  = exp_q.pop_front();
        pa = e.src[0];
        pb = e.src[1];
        if (e.src == 2'd3) begin
          known_a = 0; known_b = 0;
          rc_exp[sel] = rc_exp[sel] + 1'b1;
        end else begin
          if (rema == 0) known_a = 1;
          if (remb == 0) known_b = 1;
        end
      end
      n_tests++;
      if ({a_pop, b_pop, stall} !== {pa, pb, !fire}) begin
        n_fail++;
        $display("FAIL pop_stall: got a_pop=%0b b_pop=%0b stall=%0b expected %0b %0b %0b",
                 a_pop, b_pop, stall, pa, pb, !fire);
      end
      if (pa) begin void'(qa.pop_front()); a_shown = 0; end
      if (pb) begin void'(qb.pop_front()); b_shown = 0; end
      exp_push = fire;
      if (fire) exp_data = e.d;
      c++;
      @(negedge clk);
    end
    if (!partial) begin
      a_empty = 1; b_empty = 1; out_full = 0;
      @(negedge clk);
      exp_push = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({state_o, out_push, out_data, run_count} !== {2'b00, 1'b0, 64'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL %s_regs: got state=%0d push=%0b data=%h count=%0d expected 0 0 0 0",
               tag, state_o, out_push, out_data, run_count);
    end
    n_tests++;
    if ({a_pop, b_pop} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_pops: got a_pop=%0b b_pop=%0b expected 0 0", tag, a_pop, b_pop);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_data = {32'd5, 32'h1234}; b_data = {32'd6, 32'h5678};
    a_empty = 0; b_empty = 0; out_full = 0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_reset_outputs("reset");
    end
    sel = 0;
    a_empty = 1; b_empty = 1;
    flush_model();
    rc_exp[0] = '0; rc_exp[1] = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    sel = 0;
    push_a(3); push_a(7); push_b(5); push_b(9);
    close_run();
    run_merge(0, 0, 0, 0, 40, 0);
    $display("[TB] test_basic done");
  endtask

  task automatic test_tie();
    sel = 0;
    push_a(4); push_b(4);
    close_run();
    run_merge(0, 0, 0, 0, 40, 0);
    $display("[TB] test_tie done");
  endtask

  task automatic test_a_term_first();
    sel = 0;
    push_b(2); push_b(6);
    close_run();
    run_merge(0, 0, 0, 0, 40, 0);
    $display("[TB] test_a_term_first done");
  endtask

  task automatic test_full_hold();
    sel = 0;
    push_a(1); push_a(4); push_a(8); push_a(20);
    push_b(2); push_b(4); push_b(9); push_b(30);
    close_run();
    run_merge(0, 0, 3, 5, 60, 0);
    $display("[TB] test_full_hold done");
  endtask

  task automatic test_descending();
    sel = 1;
    push_a(9); push_a(2); push_b(8); push_b(1);
    close_run();
    run_merge(0, 0, 0, 0, 40, 0);
    $display("[TB] test_descending done");
  endtask

  task automatic test_back_to_back();
    sel = 0;
    for (int r = 0; r < 4; r++) add_random_run(4);
    run_merge(0, 0, 0, 0, 200, 0);
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int r = 0; r < 6; r++) add_random_run(6);
      run_merge(20, 25, 0, 0, 2000, 0);
      $display("[TB] test_random sel=%0d done", s);
    end
  endtask

  task automatic test_reset_done_b();
    sel = 0;
    push_a(3); push_a(8);
    close_run();
    run_merge(0, 0, 0, 0, 2, 1);
    a_empty = 0; a_data = qa[0];
    b_empty = 0; b_data = qb[0];
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("reset_done_b");
    flush_model();
    rc_exp[0] = '0; rc_exp[1] = '0;
    a_empty = 1; b_empty = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    push_a(11); push_b(10);
    close_run();
    run_merge(0, 0, 0, 0, 40, 0);
    $display("[TB] test_reset_done_b done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_a_term_first();
    test_full_hold();
    test_descending();
    test_back_to_back();
    test_random();
    test_reset_done_b();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
